rra_grant_mux: RTL and testbench

- Downstream stage of the 4-requester round-robin arbiter (rra).
- Consumes the arbiter's one-hot grants gnt3..gnt0 and forwards the granted requester's data words onto one shared output channel with valid/ready handshake.
- Inserts a one-cycle switch bubble on every change of owner, counts beats per grant tenure, and flags illegal (multi-hot) grant patterns.

---
 rtl/rra_pkg.sv | 42 ++++
 rtl/rra_out_stage.sv | 46 ++++
 rtl/rra_grant_mux.sv | 167 ++++++++++++++++
 tb/tb_rra_grant_mux.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rra_pkg.sv
// -----------------------------------------------------------------------------
// rra_pkg
// Shared definitions for the round-robin arbiter (rra) family.
//   NUM_REQ      : number of requesters served by the arbiter.
//   state_t      : FSM state encoding used by rra_grant_mux.
//   grant_info_t : decoded view of a 4-bit grant vector.
//   onehot4()    : classifies a grant vector as one-hot / multi-hot and
//                  returns the index of the set bit.
// -----------------------------------------------------------------------------
package rra_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SWITCH  = 2'd1;
    localparam state_t ST_FORWARD = 2'd2;

    typedef struct packed {
        logic       onehot;  // exactly one grant bit set
        logic       multi;   // two or more grant bits set
        logic [1:0] index;   // position of the set bit, valid only when onehot
    } grant_info_t;

    function automatic grant_info_t onehot4(input logic [3:0] g);
        grant_info_t info;
        int          cnt;
        info = '0;
        cnt  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g[i]) begin
                cnt        = cnt + 1;
                info.index = 2'(i);
            end
        end
        info.onehot = (cnt == 1);
        info.multi  = (cnt >= 2);
        return info;
    endfunction

endpackage

// File: rtl/rra_out_stage.sv
// -----------------------------------------------------------------------------
// rra_out_stage
// Single-entry valid/ready output register. A loaded word appears on dout one
// cycle after the load; the register can take a new word in the same cycle
// the old one drains, giving one beat per cycle under continuous ready.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load         : a word is transferred into the register this cycle
//   load_data    : word to store
//   accept_slot  : the register can take a word this cycle (combinational)
//   dout         : registered output word, holds its value after draining
//   dout_vld     : output word valid
//   dout_rdy     : downstream ready
// -----------------------------------------------------------------------------
module rra_out_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    output logic          accept_slot,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy
);

    // Empty, or the current word leaves on this edge.
    assign accept_slot = !dout_vld || dout_rdy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (load) begin
            dout     <= load_data;
            dout_vld <= 1'b1;
        end else if (dout_rdy) begin
            // Drain with no refill: only valid drops, data is kept.
            dout_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/rra_grant_mux.sv
// -----------------------------------------------------------------------------
// rra_grant_mux
// Downstream stage of the 4-requester round-robin arbiter. Follows the
// arbiter's one-hot grants, forwards the granted requester's words onto one
// shared valid/ready channel, inserts a one-cycle bubble on every owner
// change, counts accepted beats per tenure (saturating) and flags multi-hot
// grant vectors with a sticky error.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   gnt0..gnt3        : grants from the arbiter (one-hot or zero expected)
//   din0..din3        : requester data words
//   vld0..vld3        : requester data valid
//   rdy0..rdy3        : per-requester ready (combinational)
//   dout, dout_vld    : registered shared output channel
//   dout_rdy          : downstream ready
//   owner             : index of the current owner (registered)
//   owner_vld         : high while forwarding
//   tenure_beats      : beats accepted in the current tenure (saturating)
//   err_grant         : sticky multi-hot grant flag
// -----------------------------------------------------------------------------
module rra_grant_mux
    import rra_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gnt0,
    input  logic          gnt1,
    input  logic          gnt2,
    input  logic          gnt3,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    input  logic          vld0,
    input  logic          vld1,
    input  logic          vld2,
    input  logic          vld3,
    output logic          rdy0,
    output logic          rdy1,
    output logic          rdy2,
    output logic          rdy3,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic [1:0]    owner,
    output logic          owner_vld,
    output logic [CW-1:0] tenure_beats,
    output logic          err_grant
);

    localparam logic [CW-1:0] TENURE_MAX = '1;

    logic [3:0]    g;
    logic [3:0]    vld_vec;
    logic [3:0]    rdy_vec;
    grant_info_t   gi;
    state_t        state;
    state_t        state_nxt;
    logic [1:0]    owner_nxt;
    logic          restart;
    logic          own_held;
    logic          accept_slot;
    logic          xfer;
    logic [DW-1:0] sel_data;

    assign g       = {gnt3, gnt2, gnt1, gnt0};
    assign vld_vec = {vld3, vld2, vld1, vld0};
    assign gi      = onehot4(g);

    // The current owner still holds a clean grant. A multi-hot vector never
    // qualifies, so it behaves like no grant at all.
    assign own_held = gi.onehot && g[owner];

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        restart   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gi.onehot) begin
                    state_nxt = ST_SWITCH;
                    owner_nxt = gi.index;
                    restart   = 1'b1;
                end
            end
            ST_SWITCH, ST_FORWARD: begin
                if (own_held) begin
                    state_nxt = ST_FORWARD;
                end else if (gi.onehot) begin
                    // Direct hop to another owner: new bubble, no IDLE pass.
                    state_nxt = ST_SWITCH;
                    owner_nxt = gi.index;
                    restart   = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Only the owner can be ready, only while forwarding under its own clean
    // grant and only when the output register has room.
    always_comb begin
        rdy_vec = 4'b0000;
        if ((state == ST_FORWARD) && own_held && accept_slot) begin
            rdy_vec = 4'b0001 << owner;
        end
    end

    assign {rdy3, rdy2, rdy1, rdy0} = rdy_vec;
    assign xfer                     = |(rdy_vec & vld_vec);
    assign owner_vld                = (state == ST_FORWARD);

    always_comb begin
        sel_data = din0;
        case (owner)
            2'd0:    sel_data = din0;
            2'd1:    sel_data = din1;
            2'd2:    sel_data = din2;
            default: sel_data = din3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            owner        <= 2'd0;
            tenure_beats <= '0;
            err_grant    <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (gi.multi) begin
                err_grant <= 1'b1;
            end
            // A restart and a transfer never coincide: a transfer needs the
            // old owner's clean grant, a restart needs a different one.
            if (restart) begin
                tenure_beats <= '0;
            end else if (xfer && (tenure_beats != TENURE_MAX)) begin
                tenure_beats <= tenure_beats + 1'b1;
            end
        end
    end

    rra_out_stage #(
        .DW (DW)
    ) u_out_stage (
        .clk         (clk),
        .rst         (rst),
        .load        (xfer),
        .load_data   (sel_data),
        .accept_slot (accept_slot),
        .dout        (dout),
        .dout_vld    (dout_vld),
        .dout_rdy    (dout_rdy)
    );

endmodule

// File: tb/tb_rra_grant_mux.sv
// -----------------------------------------------------------------------------
// tb_rra_grant_mux
// Directed stimulus with a scoreboard: each phase pushes the words it expects
// on the output channel; a monitor pops and compares every word the DUT hands
// downstream. A second instance with CW=4 shares all inputs to observe
// counter saturation.
// -----------------------------------------------------------------------------
module tb_rra_grant_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] gnt = 4'b0000;
    logic [3:0] vld = 4'b0000;
    logic [7:0] din [4];
    logic       dout_rdy = 1'b0;

    wire  [3:0] rdy;
    wire  [7:0] dout;
    wire        dout_vld;
    wire  [1:0] owner;
    wire        owner_vld;
    wire  [7:0] tenure;
    wire        err_grant;

    wire  [3:0] s_rdy;
    wire  [7:0] s_dout;
    wire        s_dout_vld;
    wire  [1:0] s_owner;
    wire        s_owner_vld;
    wire  [3:0] s_tenure;
    wire        s_err_grant;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];
    int         sent [4];
    logic [7:0] base [4];

    always #5 clk = ~clk;

    rra_grant_mux #(.DW(8), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .vld0(vld[0]), .vld1(vld[1]), .vld2(vld[2]), .vld3(vld[3]),
        .rdy0(rdy[0]), .rdy1(rdy[1]), .rdy2(rdy[2]), .rdy3(rdy[3]),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .owner(owner), .owner_vld(owner_vld),
        .tenure_beats(tenure), .err_grant(err_grant)
    );

    rra_grant_mux #(.DW(8), .CW(4)) dut_sat (
        .clk(clk), .rst(rst),
        .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .vld0(vld[0]), .vld1(vld[1]), .vld2(vld[2]), .vld3(vld[3]),
        .rdy0(s_rdy[0]), .rdy1(s_rdy[1]), .rdy2(s_rdy[2]), .rdy3(s_rdy[3]),
        .dout(s_dout), .dout_vld(s_dout_vld), .dout_rdy(dout_rdy),
        .owner(s_owner), .owner_vld(s_owner_vld),
        .tenure_beats(s_tenure), .err_grant(s_err_grant)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(first + 8'(k));
    endtask

    // One clock: note which requesters handshake on the coming edge, then
    // advance their data words just after the edge.
    task automatic step();
        logic [3:0] acc;
        @(negedge clk);
        acc = vld & rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                sent[i]++;
                din[i] = base[i] + 8'(sent[i]);
            end
        end
    endtask

    // Scoreboard monitor: a word leaves whenever valid and ready meet.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && dout_vld && dout_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", dout, $time);
                end else begin
                    check("dout_word", {24'h0, dout}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        base[0] = 8'h10; base[1] = 8'h80; base[2] = 8'h40; base[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            din[i]  = base[i];
        end

        // Reset state
        #2;
        check("rst_dout", dout, 0);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_owner", owner, 0);
        check("rst_owner_vld", owner_vld, 0);
        check("rst_tenure", tenure, 0);
        check("rst_err", err_grant, 0);
        check("rst_rdy", rdy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(); step();
        #1;
        check("idle_owner_vld", owner_vld, 0);
        check("idle_rdy", rdy, 0);
        check("idle_dout_vld", dout_vld, 0);

        // Single owner: 20 beats on requester 0
        push_seq(8'h10, 20);
        gnt = 4'b0001; vld = 4'b0001; dout_rdy = 1'b1;
        #1 check("a_rdy_in_idle", rdy, 0);
        step();
        #1;
        check("a_rdy_in_switch", rdy, 0);
        check("a_owner_vld_switch", owner_vld, 0);
        step();
        #1;
        check("a_rdy_forward", rdy, 4'b0001);
        check("a_owner_vld_fwd", owner_vld, 1);
        check("a_owner", owner, 0);
        for (int c = 0; c < 40 && sent[0] < 20; c++) step();
        vld = 4'b0000;
        #1;
        check("a_beats", sent[0], 20);
        check("a_tenure", tenure, 20);
        step();

        // Backpressure: stall 5 cycles with 0x26 held in the register
        push_seq(8'h24, 10);
        vld = 4'b0001;
        repeat (3) step();
        dout_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("b_stall_rdy", rdy, 0);
            check("b_stall_dout", dout, 8'h26);
            check("b_stall_vld", dout_vld, 1);
            step();
        end
        dout_rdy = 1'b1;
        for (int c = 0; c < 40 && sent[0] < 30; c++) step();
        vld = 4'b0000;
        #1 check("b_beats", sent[0], 30);
        step();

        // Owner hop 0 -> 1 with vld0 still high when gnt0 falls
        push_seq(8'h2E, 10);
        push_seq(8'h80, 4);
        vld = 4'b0001;
        repeat (10) step();
        check("c_beats_owner0", sent[0], 40);
        gnt = 4'b0010; vld = 4'b0011;
        #1;
        check("c_hop_rdy", rdy, 0);
        check("c_pending_vld", dout_vld, 1);
        check("c_pending_word", dout, 8'h37);
        step();
        #1;
        check("c_bubble_rdy", rdy, 0);
        check("c_bubble_owner", owner, 1);
        check("c_bubble_owner_vld", owner_vld, 0);
        check("c_bubble_tenure", tenure, 0);
        check("c_drained", dout_vld, 0);
        step();
        #1;
        check("c_rdy_owner1", rdy, 4'b0010);
        check("c_owner_vld", owner_vld, 1);
        for (int c = 0; c < 20 && sent[1] < 4; c++) step();
        vld = 4'b0000;
        #1;
        check("c_beats_owner1", sent[1], 4);
        check("c_no_late_owner0", sent[0], 40);
        step();

        // Illegal grant, then recovery on owner 2 (saturation on CW=4)
        gnt = 4'b0101; vld = 4'b0101;
        #1;
        check("d_multi_rdy", rdy, 0);
        check("d_err_before_edge", err_grant, 0);
        step();
        #1;
        check("d_err_set", err_grant, 1);
        check("d_idle_after_multi", owner_vld, 0);
        check("d_no_transfer", dout_vld, 0);
        push_seq(8'h40, 20);
        gnt = 4'b0100; vld = 4'b0100;
        #1 check("e_rdy_in_idle", rdy, 0);
        for (int c = 0; c < 60 && sent[2] < 20; c++) step();
        vld = 4'b0000;
        #1;
        check("e_beats", sent[2], 20);
        check("e_tenure_cw8", tenure, 20);
        check("e_tenure_cw4_sat", s_tenure, 15);
        check("e_err_sticky", err_grant, 1);
        check("e_owner", owner, 2);
        step();

        // Async reset with a word held in the register
        vld = 4'b0100; dout_rdy = 1'b0;
        step();
        #1;
        check("f_full_vld", dout_vld, 1);
        check("f_full_word", dout, 8'h54);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("f_rst_dout", dout, 0);
        check("f_rst_dout_vld", dout_vld, 0);
        check("f_rst_owner", owner, 0);
        check("f_rst_owner_vld", owner_vld, 0);
        check("f_rst_tenure", tenure, 0);
        check("f_rst_err", err_grant, 0);
        check("f_rst_rdy", rdy, 0);
        gnt = 4'b0000; vld = 4'b0000; dout_rdy = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        #1;
        check("f_idle_owner_vld", owner_vld, 0);
        check("f_idle_rdy", rdy, 0);
        check("f_idle_dout_vld", dout_vld, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
